control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 opcode  input  4  instruction-register upper nibble; valid from step T2.
REQ-004 CARRY  input  1  ALU carry flag (combinational from datapath).
REQ-005 ZERO  input  1  ALU zero flag (combinational from datapath).
REQ-006 HLT, MI, RI, RO, IO, II, AI, AO, EO, SUB, BI, OI, CE, CO, J, FI  output  1 each  datapath control lines.
REQ-007 step  output  3  current microstep, T0..T4 encoded 0..4.
REQ-008 halted  output  1  sequencer stopped.

Function
REQ-009 The step counter SHALL advance T0->T1->T2->T3->T4->T0 on each rising clk while not halted; there is no early termination, so every instruction takes 5 cycles.
REQ-010 Control outputs SHALL be combinational decode of (step, opcode, CF, ZF); the datapath latches on the edge that ends the step.
REQ-011 Fetch, all opcodes: T0 = CO MI; T1 = RO II CE.
REQ-012 LDA 0001: T2 IO MI; T3 RO AI.
REQ-013 ADD 0010: T2 IO MI; T3 RO BI; T4 EO AI FI.
REQ-014 SUB 0011: T2 IO MI; T3 RO BI SUB; T4 EO AI SUB FI.
REQ-015 STA 0100: T2 IO MI; T3 AO RI.
REQ-016 LDI 0101: T2 IO AI.
REQ-017 JMP 0110: T2 IO J.
REQ-018 JC 0111: T2 IO J only if CF=1; JZ 1000: T2 IO J only if ZF=1; otherwise no lines asserted.
REQ-019 OUT 1110: T2 AO OI.
REQ-020 HLT 1111: T2 asserts HLT; on that edge, halted is set and step freezes at T2.
REQ-021 Unlisted opcodes SHALL behave as NOP, with T2-T4 all-zero.
REQ-022 Steps not listed for an opcode SHALL drive all control lines 0.
REQ-023 Flag register: CF<=CARRY and ZF<=ZERO on a rising edge where FI=1; otherwise hold.
REQ-024 While halted: all control outputs except HLT are 0; HLT stays 1; step, CF and ZF hold; exit is by rst only.

Reset
REQ-025 On rst assertion, asynchronously: step=0, CF=0, ZF=0, halted=0.
REQ-026 While rst=1, all control outputs SHALL be 0.
REQ-027 After rst deasserts, outputs SHALL reflect T0 (CO MI) in the same cycle.
REQ-028 Reset mid-instruction SHALL abandon the instruction, with no partial state retained.

Configuration
REQ-029 The macro CTRL_COND_JUMP_EN SHALL control conditional jumps.
- Defined: CF/ZF register present; JC/JZ behave per REQ-018; FI asserted per REQ-013/014.
- Undefined: flag register omitted; FI tied 0; JC and JZ decode as NOP; CARRY and ZERO are unused.

Structure
REQ-030 A shared package ctrl_pkg SHALL hold:
- opcode constants;
- the microstep enum T0..T4;
- the control-word bit-index constants.
REQ-031 Split:
- The opcode/step/flag decode SHALL be a combinational sub-module, microcode_rom.
- The step counter, flag register and halt latch SHALL stay in control_sequencer.

Verification
REQ-032 Reset release, opcode=0000: T0 CO MI=1; T1 RO II CE=1; T2-T4 all zero; step returns to 0 at cycle 5.
REQ-033 ADD with CARRY=1, ZERO=0 at T4:
- T3 RO BI;
- T4 EO AI FI;
- afterwards CF=1, ZF=0.
REQ-034 JZ, ZF=1 vs ZF=0:
- ZF=1: T2 asserts IO J.
- ZF=0: T2 all zero.
- Macro undefined: T2 all zero in both cases.
REQ-035 HLT: T2 HLT=1; then halted=1 and step=2 held for 10 cycles with other outputs 0; rst clears halted and step=0.
REQ-036 rst asserted mid-T3 of SUB: outputs go 0 immediately, without waiting for clk; after release, step=0 and CF=ZF=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, microsteps and control-word bit positions.
// Conditional jumps are enabled by defining CTRL_COND_JUMP_EN.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam int CW_W   = 16;
  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_IO  = 11;
  localparam int CW_II  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_EO  = 7;
  localparam int CW_SUB = 6;
  localparam int CW_BI  = 5;
  localparam int CW_OI  = 4;
  localparam int CW_CE  = 3;
  localparam int CW_CO  = 2;
  localparam int CW_J   = 1;
  localparam int CW_FI  = 0;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word.
// JC/JZ and FI are only decoded when CTRL_COND_JUMP_EN is defined.
module microcode_rom
  import ctrl_pkg::*;
(
  input  logic [2:0]      i_step,
  input  logic [3:0]      i_opcode,
  input  logic            i_cf,
  input  logic            i_zf,
  output logic [CW_W-1:0] o_cw
);

`ifndef CTRL_COND_JUMP_EN
  logic w_unused_flags;
  assign w_unused_flags = i_cf ^ i_zf;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_cw = '0;
    case (i_step)
      T0: begin
        o_cw[CW_CO] = 1'b1;
        o_cw[CW_MI] = 1'b1;
      end
      T1: begin
        o_cw[CW_RO] = 1'b1;
        o_cw[CW_II] = 1'b1;
        o_cw[CW_CE] = 1'b1;
      end
      T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_cw[CW_IO] = 1'b1;
            o_cw[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            o_cw[CW_IO] = 1'b1;
            o_cw[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            o_cw[CW_IO] = 1'b1;
            o_cw[CW_J]  = 1'b1;
          end
`ifdef CTRL_COND_JUMP_EN
          OP_JC: begin
            o_cw[CW_IO] = i_cf;
            o_cw[CW_J]  = i_cf;
          end
          OP_JZ: begin
            o_cw[CW_IO] = i_zf;
            o_cw[CW_J]  = i_zf;
          end
`endif
          OP_OUT: begin
            o_cw[CW_AO] = 1'b1;
            o_cw[CW_OI] = 1'b1;
          end
          OP_HLT:  o_cw[CW_HLT] = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_cw[CW_RO] = 1'b1;
            o_cw[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_cw[CW_RO]  = 1'b1;
            o_cw[CW_BI]  = 1'b1;
            o_cw[CW_SUB] = (i_opcode == OP_SUB);
          end
          OP_STA: begin
            o_cw[CW_AO] = 1'b1;
            o_cw[CW_RI] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_cw[CW_EO]  = 1'b1;
          o_cw[CW_AI]  = 1'b1;
          o_cw[CW_SUB] = (i_opcode == OP_SUB);
`ifdef CTRL_COND_JUMP_EN
          o_cw[CW_FI]  = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Five-step microcode sequencer: step counter, halt latch, optional CF/ZF flag register.
// Define CTRL_COND_JUMP_EN to build the flag register and enable JC/JZ.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       CARRY,
  input  logic       ZERO,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SUB,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step,
  output logic       halted
);

  step_t           r_step, w_step_next;
  logic            r_halted, w_halted_next;
  logic            w_cf, w_zf;
  logic [CW_W-1:0] w_rom_cw, w_cw;

  microcode_rom u_rom (
    .i_step   (r_step),
    .i_opcode (opcode),
    .i_cf     (w_cf),
    .i_zf     (w_zf),
    .o_cw     (w_rom_cw)
  );

  always_comb begin
    w_step_next   = r_step;
    w_halted_next = r_halted;
    if (!r_halted) begin
      if (w_rom_cw[CW_HLT]) begin
        w_halted_next = 1'b1;
      end else begin
        case (r_step)
          T0:      w_step_next = T1;
          T1:      w_step_next = T2;
          T2:      w_step_next = T3;
          T3:      w_step_next = T4;
          default: w_step_next = T0;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_next;
      r_halted <= w_halted_next;
    end
  end

`ifdef CTRL_COND_JUMP_EN
  logic r_cf, r_zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cf <= 1'b0;
      r_zf <= 1'b0;
    end else if (w_cw[CW_FI]) begin
      r_cf <= CARRY;
      r_zf <= ZERO;
    end
  end

  assign w_cf = r_cf;
  assign w_zf = r_zf;
`else
  logic w_unused_datapath_flags;
  assign w_unused_datapath_flags = CARRY ^ ZERO;
  assign w_cf = 1'b0;
  assign w_zf = 1'b0;
`endif

  // Reset gates the outputs combinationally so the datapath sees zeros before any edge.
  always_comb begin
    w_cw = w_rom_cw;
    if (rst) begin
      w_cw = '0;
    end else if (r_halted) begin
      w_cw         = '0;
      w_cw[CW_HLT] = 1'b1;
    end
  end

  assign HLT    = w_cw[CW_HLT];
  assign MI     = w_cw[CW_MI];
  assign RI     = w_cw[CW_RI];
  assign RO     = w_cw[CW_RO];
  assign IO     = w_cw[CW_IO];
  assign II     = w_cw[CW_II];
  assign AI     = w_cw[CW_AI];
  assign AO     = w_cw[CW_AO];
  assign EO     = w_cw[CW_EO];
  assign SUB    = w_cw[CW_SUB];
  assign BI     = w_cw[CW_BI];
  assign OI     = w_cw[CW_OI];
  assign CE     = w_cw[CW_CE];
  assign CO     = w_cw[CW_CO];
  assign J      = w_cw[CW_J];
  assign FI     = w_cw[CW_FI];
  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer; expectations track CTRL_COND_JUMP_EN.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
  localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
  localparam logic [15:0] B_EO  = 16'h0080, B_SUB = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J = 16'h0002, B_FI = 16'h0001;
`ifdef CTRL_COND_JUMP_EN
  localparam logic [15:0] FI_EXP = B_FI;
  localparam logic [15:0] JT_EXP = B_IO | B_J;
`else
  localparam logic [15:0] FI_EXP = 16'h0000;
  localparam logic [15:0] JT_EXP = 16'h0000;
`endif

  typedef struct {
    logic [3:0]  op;
    logic        carry;
    logic        zero;
    logic [2:0]  stp;
    logic [15:0] cw;
    logic        hlt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic CARRY = 1'b0, ZERO = 1'b0;
  logic HLT, MI, RI, RO, IO, II, AI, AO, EO, SUB, BI, OI, CE, CO, J, FI;
  logic [2:0] step;
  logic halted;
  logic [15:0] cw_obs;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .CARRY(CARRY), .ZERO(ZERO),
    .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI), .AO(AO),
    .EO(EO), .SUB(SUB), .BI(BI), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
    .step(step), .halted(halted)
  );

  assign cw_obs = {HLT, MI, RI, RO, IO, II, AI, AO, EO, SUB, BI, OI, CE, CO, J, FI};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_instr(input logic [3:0] op, input logic c, input logic z,
                           input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4);
    logic [15:0] exp_cw[5];
    exp_cw[0] = B_CO | B_MI;
    exp_cw[1] = B_RO | B_II | B_CE;
    exp_cw[2] = t2;
    exp_cw[3] = t3;
    exp_cw[4] = t4;
    for (int s = 0; s < 5; s++)
      vecs.push_back('{op: op, carry: c, zero: z, stp: 3'(s), cw: exp_cw[s], hlt: 1'b0});
  endtask

  // Called at posedge+1: drive, sample at negedge, return at next posedge+1.
  task automatic run_vec(input vec_t v, input string tag);
    opcode = v.op;
    CARRY  = v.carry;
    ZERO   = v.zero;
    @(negedge clk);
    check({tag, " cw"}, cw_obs, v.cw);
    check({tag, " step"}, 16'(step), 16'(v.stp));
    check({tag, " halted"}, 16'(halted), 16'(v.hlt));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;

    add_instr(4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    add_instr(4'b0001, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_AI, 16'h0);
    add_instr(4'b0010, 1'b1, 1'b0, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | FI_EXP);
    add_instr(4'b0111, 1'b0, 1'b0, JT_EXP, 16'h0, 16'h0);
    add_instr(4'b1000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    add_instr(4'b0011, 1'b0, 1'b1, B_IO | B_MI, B_RO | B_BI | B_SUB, B_EO | B_AI | B_SUB | FI_EXP);
    add_instr(4'b1000, 1'b0, 1'b0, JT_EXP, 16'h0, 16'h0);
    add_instr(4'b0111, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    add_instr(4'b0100, 1'b0, 1'b0, B_IO | B_MI, B_AO | B_RI, 16'h0);
    add_instr(4'b0101, 1'b0, 1'b0, B_IO | B_AI, 16'h0, 16'h0);
    add_instr(4'b0110, 1'b0, 1'b0, B_IO | B_J, 16'h0, 16'h0);
    add_instr(4'b1110, 1'b0, 1'b0, B_AO | B_OI, 16'h0, 16'h0);
    add_instr(4'b1001, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
    add_instr(4'b1101, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

    // Reset state: outputs held low while rst is high.
    #2;
    check("reset cw", cw_obs, 16'h0);
    check("reset step", 16'(step), 16'h0);
    check("reset halted", 16'(halted), 16'h0);
    apply_reset();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d op%b T%0d", i, vecs[i].op, vecs[i].stp));
    check("wrap step", 16'(step), 16'h0);

    // HLT: latch at T2, hold for 10 cycles regardless of opcode, exit by rst.
    apply_reset();
    run_vec('{4'hF, 1'b0, 1'b0, 3'd0, B_CO | B_MI, 1'b0}, "hlt T0");
    run_vec('{4'hF, 1'b0, 1'b0, 3'd1, B_RO | B_II | B_CE, 1'b0}, "hlt T1");
    run_vec('{4'hF, 1'b0, 1'b0, 3'd2, B_HLT, 1'b0}, "hlt T2");
    for (int k = 0; k < 10; k++) begin
      v = '{4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'd2, B_HLT, 1'b1};
      run_vec(v, $sformatf("halted c%0d", k));
    end
    #2;
    rst = 1'b1;
    #1;
    check("hlt rst async cw", cw_obs, 16'h0);
    check("hlt rst async step", 16'(step), 16'h0);
    check("hlt rst async halted", 16'(halted), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec('{4'h0, 1'b0, 1'b0, 3'd0, B_CO | B_MI, 1'b0}, "post hlt T0");

    // Reset mid-T3 of SUB after an ADD that set both flags.
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      v = '{4'b0010, 1'b1, 1'b1, 3'(s), 16'h0, 1'b0};
      case (s)
        0: v.cw = B_CO | B_MI;
        1: v.cw = B_RO | B_II | B_CE;
        2: v.cw = B_IO | B_MI;
        3: v.cw = B_RO | B_BI;
        default: v.cw = B_EO | B_AI | FI_EXP;
      endcase
      run_vec(v, $sformatf("pre add T%0d", s));
    end
    run_vec('{4'b0011, 1'b1, 1'b1, 3'd0, B_CO | B_MI, 1'b0}, "sub T0");
    run_vec('{4'b0011, 1'b1, 1'b1, 3'd1, B_RO | B_II | B_CE, 1'b0}, "sub T1");
    run_vec('{4'b0011, 1'b1, 1'b1, 3'd2, B_IO | B_MI, 1'b0}, "sub T2");
    @(negedge clk);
    check("sub T3 cw", cw_obs, B_RO | B_BI | B_SUB);
    #1;
    rst = 1'b1;
    #1;
    check("sub rst async cw", cw_obs, 16'h0);
    check("sub rst async step", 16'(step), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 10; s++) begin
      v = '{(s < 5) ? 4'b0111 : 4'b1000, 1'b1, 1'b1, 3'(s % 5), 16'h0, 1'b0};
      if (s % 5 == 0) v.cw = B_CO | B_MI;
      if (s % 5 == 1) v.cw = B_RO | B_II | B_CE;
      run_vec(v, $sformatf("post rst %s T%0d", (s < 5) ? "JC" : "JZ", s % 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
